imgproc_mode_ctrl: RTL
======================

Name: imgproc_mode_ctrl

Overview:
- Controller that owns the 4-bit processing-mode input of the image-processing IP in the vision pipeline.
- Accepts mode-change commands from two sources:
  - 3-byte framed commands from the ESP UART receive byte stream;
  - the two board keys.
- Validates each request, then applies it to the mode output only at a camera end-of-frame, so a frame never mixes modes.
- Returns a one-byte acknowledge to the ESP UART transmit path.

Parameters:
- HDR_BYTE, 8'hA5, command header byte.
- BYTE_TIMEOUT, 1_000_000, maximum clk cycles between bytes of one command (20 ms at 50 MHz).
- DEBOUNCE_CYC, 250_000, cycles a key level must stay stable before it is accepted.

Ports:
- clk  in  1  system clock (50 MHz)
- reset_n  in  1  asynchronous active-low reset
- rx_data  in  8  received UART byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  byte accepted when rx_valid && rx_ready
- key_n  in  2  raw active-low keys: [0] = mode+1, [1] = mode 0
- fval  in  1  camera frame-valid, asynchronous to clk
- mode  out  4  applied processing mode
- mode_pending  out  1  validated request waiting for end-of-frame
- ack_data  out  8  acknowledge byte to UART TX
- ack_valid  out  1  ack_data valid, held until ack_ready
- ack_ready  in  1  UART TX accepts ack
- err_cnt  out  8  saturating protocol-error count

Behaviour:
- Reset values (asynchronous, all registers): mode=0, mode_pending=0, ack_valid=0, ack_data=0, err_cnt=0, rx_ready=0, state=IDLE.
  - rx_ready is registered and rises on the first clk edge after reset_n deasserts.
- States: IDLE, GOT_HDR, GOT_MODE, PEND, ACK.
  - rx_ready=1 only in IDLE, GOT_HDR and GOT_MODE.
- IDLE:
  - Accepted byte == HDR_BYTE → GOT_HDR. Any other byte is discarded silently.
  - Debounced key event (accepted only in IDLE) → latch request, src=KEY, go to PEND.
    - key[0]: request = mode+1, with 15 wrapping to 0.
    - key[1]: request = 0.
    - If both keys fire in the same cycle, key[1] wins.
  - Key events in any other state are dropped.
- GOT_HDR: accepted byte b → latch b, go to GOT_MODE.
- GOT_MODE: accepted checksum byte c.
  - Valid when c == HDR_BYTE ^ b and b[7:4] == 0 → request = b[3:0], src=UART, go to PEND.
  - Otherwise → err_cnt+1, ack_data = 8'hEE, ack_valid = 1, go to ACK.
- Inter-byte timeout:
  - Counter resets on every accepted byte.
  - Reaching BYTE_TIMEOUT in GOT_HDR or GOT_MODE → err_cnt+1, return to IDLE, no ack.
- PEND:
  - mode_pending = 1.
  - Apply condition true → mode <= request, mode_pending <= 0.
    - src=UART: ack_data = {4'hA, request}, ack_valid = 1, go to ACK.
    - src=KEY: go to IDLE.
- ACK: hold ack_valid and ack_data until ack_ready is sampled high, then clear ack_valid and go to IDLE.
- Latency with frame sync off: mode and ack_valid update on the edge after checksum acceptance (1 cycle).
- err_cnt saturates at 255.
- Reset asserted mid-command or in PEND discards the request; mode returns to 0.

Optional Feature:
- Macro: IMGPROC_MODE_CTRL_FRAME_SYNC_EN.
- Defined:
  - fval passes through a 2-flop synchronizer plus an edge register.
  - The apply condition is the synchronized falling edge (end of frame), so mode changes 3 clk cycles after the fval pin falls.
  - If fval stays low (camera idle), PEND waits indefinitely.
- Undefined: the apply condition is constant 1, and fval is unused.

Decomposition:
- Package imgproc_mode_ctrl_pkg holds:
  - state enum;
  - ACK_OK_NIB = 4'hA;
  - ACK_ERR = 8'hEE;
  - src enum (UART, KEY).
- One sub-module, key_debounce, instantiated twice:
  - 2-flop synchronizer plus stability counter of DEBOUNCE_CYC;
  - outputs a one-cycle press pulse on the debounced high→low transition.

Test Plan:
- Frame sync off; send A5,03,A6 with ack_ready=1 → mode=3 one cycle after the 3rd byte; ack_data=8'hA3 pulses one cycle; err_cnt=0.
- Send A5,03,00 → mode unchanged; ack_data=8'hEE; err_cnt=1. Send A5,13,B6 (mode byte out of range) → 8'hEE; err_cnt=2.
- Send A5 then idle for BYTE_TIMEOUT cycles → return to IDLE with no ack; err_cnt+1; a following A5,05,A0 applies mode=5.
- Frame sync on; fval high; send A5,07,A2 → mode_pending=1 and mode held; drop fval → mode=7 exactly 3 cycles later; mode_pending=0.
- Mode=15, key_n[0] low for DEBOUNCE_CYC+10 → mode=0 (wrap); a 100-cycle glitch on key_n[1] → no change; hold ack_ready=0 after a valid command → ack_valid stays high and rx_ready=0 until ack_ready is asserted.
- Assert reset_n low while in PEND → mode=0, mode_pending=0, ack_valid=0 immediately; rx_ready=1 one cycle after release.

Source files
------------

// File: rtl/imgproc_mode_ctrl_pkg.sv
// imgproc_mode_ctrl_pkg: shared types and constants for the
// image-processing mode controller.
package imgproc_mode_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GOT_HDR,
        GOT_MODE,
        PEND,
        ACK
    } state_t;

    typedef enum logic {
        SRC_UART,
        SRC_KEY
    } src_t;

    localparam logic [3:0] ACK_OK_NIB = 4'hA;
    localparam logic [7:0] ACK_ERR    = 8'hEE;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/imgproc_mode_ctrl_key_debounce.sv
// key_debounce: synchronizes a raw active-low key and emits a
// one-cycle pulse when the stable level goes from released to pressed.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYC = 250_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_key_n,
    output logic o_press
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYC + 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_press;
    logic [CW-1:0] r_cnt;

    // two-flop synchronizer, idles at the released level
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_key_n;
            r_sync2 <= r_sync1;
        end
    end

    // accept a new level only after it has been stable long enough
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_level <= 1'b1;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_press <= 1'b0;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DEBOUNCE_CYC - 1)) begin
                r_cnt   <= '0;
                r_level <= r_sync2;
                r_press <= ~r_sync2;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/imgproc_mode_ctrl.sv
// imgproc_mode_ctrl: owns the processing-mode output; takes UART/key requests.
// Optional IMGPROC_MODE_CTRL_FRAME_SYNC_EN applies requests only at end-of-frame.
module imgproc_mode_ctrl
    import imgproc_mode_ctrl_pkg::*;
#(
    parameter logic [7:0]  HDR_BYTE     = 8'hA5,
    parameter int unsigned BYTE_TIMEOUT = 1_000_000,
    parameter int unsigned DEBOUNCE_CYC = 250_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    input  logic [1:0] key_n,
    input  logic       fval,
    output logic [3:0] mode,
    output logic       mode_pending,
    output logic [7:0] ack_data,
    output logic       ack_valid,
    input  logic       ack_ready,
    output logic [7:0] err_cnt
);

    localparam int unsigned TW = $clog2(BYTE_TIMEOUT + 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [3:0]    r_mode;
    logic [3:0]    w_mode_nxt;
    logic [3:0]    r_req;
    logic [3:0]    w_req_nxt;
    src_t          r_src;
    src_t          w_src_nxt;
    logic [7:0]    r_byte;
    logic [7:0]    w_byte_nxt;
    logic [7:0]    r_ack_data;
    logic [7:0]    w_ack_data_nxt;
    logic          r_ack_valid;
    logic          w_ack_valid_nxt;
    logic [7:0]    r_err;
    logic [7:0]    w_err_nxt;
    logic [TW-1:0] r_tmo;
    logic [TW-1:0] w_tmo_nxt;
    logic          r_pend;
    logic          r_rx_ready;

    logic          w_rx_fire;
    logic          w_tmo_hit;
    logic          w_key0;
    logic          w_key1;
    logic          w_apply;

    key_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_key0 (
        .clk    (clk),
        .reset_n(reset_n),
        .i_key_n(key_n[0]),
        .o_press(w_key0)
    );

    key_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_key1 (
        .clk    (clk),
        .reset_n(reset_n),
        .i_key_n(key_n[1]),
        .o_press(w_key1)
    );

`ifdef IMGPROC_MODE_CTRL_FRAME_SYNC_EN
    logic r_fval_s1;
    logic r_fval_s2;
    logic r_fval_d;

    // bring fval into the clk domain and keep one delayed copy for edges
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fval_s1 <= 1'b0;
            r_fval_s2 <= 1'b0;
            r_fval_d  <= 1'b0;
        end else begin
            r_fval_s1 <= fval;
            r_fval_s2 <= r_fval_s1;
            r_fval_d  <= r_fval_s2;
        end
    end

    assign w_apply = r_fval_d & ~r_fval_s2;
`else
    logic w_unused_fval;
    assign w_unused_fval = fval;
    assign w_apply       = 1'b1;
`endif

    assign w_rx_fire = rx_valid & r_rx_ready;
    assign w_tmo_hit = (r_tmo == TW'(BYTE_TIMEOUT - 1));

    // command parsing, validation and deferred mode application
    always_comb begin
        w_state_nxt     = r_state;
        w_mode_nxt      = r_mode;
        w_req_nxt       = r_req;
        w_src_nxt       = r_src;
        w_byte_nxt      = r_byte;
        w_ack_data_nxt  = r_ack_data;
        w_ack_valid_nxt = r_ack_valid;
        w_err_nxt       = r_err;
        w_tmo_nxt       = '0;
        unique case (r_state)
            IDLE: begin
                if (w_rx_fire && rx_data == HDR_BYTE) begin
                    w_state_nxt = GOT_HDR;
                end else if (w_key1) begin
                    w_req_nxt   = 4'h0;
                    w_src_nxt   = SRC_KEY;
                    w_state_nxt = PEND;
                end else if (w_key0) begin
                    w_req_nxt   = r_mode + 4'h1;
                    w_src_nxt   = SRC_KEY;
                    w_state_nxt = PEND;
                end
            end
            GOT_HDR: begin
                if (w_rx_fire) begin
                    w_byte_nxt  = rx_data;
                    w_state_nxt = GOT_MODE;
                end else if (w_tmo_hit) begin
                    w_err_nxt   = sat_inc8(r_err);
                    w_state_nxt = IDLE;
                end else begin
                    w_tmo_nxt = r_tmo + TW'(1);
                end
            end
            GOT_MODE: begin
                if (w_rx_fire) begin
                    if (rx_data == (HDR_BYTE ^ r_byte) &&
                        r_byte[7:4] == 4'h0) begin
                        w_req_nxt   = r_byte[3:0];
                        w_src_nxt   = SRC_UART;
                        w_state_nxt = PEND;
                    end else begin
                        w_err_nxt       = sat_inc8(r_err);
                        w_ack_data_nxt  = ACK_ERR;
                        w_ack_valid_nxt = 1'b1;
                        w_state_nxt     = ACK;
                    end
                end else if (w_tmo_hit) begin
                    w_err_nxt   = sat_inc8(r_err);
                    w_state_nxt = IDLE;
                end else begin
                    w_tmo_nxt = r_tmo + TW'(1);
                end
            end
            PEND: begin
                if (w_apply) begin
                    w_mode_nxt = r_req;
                    if (r_src == SRC_UART) begin
                        w_ack_data_nxt  = {ACK_OK_NIB, r_req};
                        w_ack_valid_nxt = 1'b1;
                        w_state_nxt     = ACK;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            ACK: begin
                if (ack_ready) begin
                    w_ack_valid_nxt = 1'b0;
                    w_state_nxt     = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // state and datapath registers; ready/pending follow the next state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_mode      <= 4'h0;
            r_req       <= 4'h0;
            r_src       <= SRC_UART;
            r_byte      <= 8'h00;
            r_ack_data  <= 8'h00;
            r_ack_valid <= 1'b0;
            r_err       <= 8'h00;
            r_tmo       <= '0;
            r_pend      <= 1'b0;
            r_rx_ready  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_mode      <= w_mode_nxt;
            r_req       <= w_req_nxt;
            r_src       <= w_src_nxt;
            r_byte      <= w_byte_nxt;
            r_ack_data  <= w_ack_data_nxt;
            r_ack_valid <= w_ack_valid_nxt;
            r_err       <= w_err_nxt;
            r_tmo       <= w_tmo_nxt;
            r_pend      <= (w_state_nxt == PEND);
            r_rx_ready  <= (w_state_nxt == IDLE) ||
                           (w_state_nxt == GOT_HDR) ||
                           (w_state_nxt == GOT_MODE);
        end
    end

    assign rx_ready     = r_rx_ready;
    assign mode         = r_mode;
    assign mode_pending = r_pend;
    assign ack_data     = r_ack_data;
    assign ack_valid    = r_ack_valid;
    assign err_cnt      = r_err;

endmodule
